// File: rtl/ble_cmd_store.sv
// Command store: parses "HH <payload>\r\n" lines from UART RX into slots and streams slots back with CR LF.
// Define CMD_MEM_DEFAULTS_EN to preload slots 0..6 with HM-10 AT commands after reset.
`timescale 1ns/1ps
module ble_cmd_store #(
   parameter int N_SLOTS  = 16,
   parameter int SLOT_LEN = 32,
   parameter int SLOT_W   = $clog2(N_SLOTS),
   parameter int LEN_W    = $clog2(SLOT_LEN+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_done,
   output logic [SLOT_W-1:0] wr_slot,
   output logic              err_valid,
   output logic [1:0]        err_code,
   input  logic              rd_req,
   input  logic [SLOT_W-1:0] rd_slot,
   output logic              rd_busy,
   output logic              rd_err,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              init_busy
);
   localparam int IDX_W = $clog2(SLOT_LEN+2);
   localparam int BI_W  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
   localparam logic [7:0] CR = 8'h0D, LF = 8'h0A, ESC = 8'h1B, SP = 8'h20;
   localparam logic [1:0] ERR_WDH = 2'd1, ERR_ADDR = 2'd2, ERR_SPACE = 2'd3;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ADDR2, S_SPACE, S_DATA, S_LF, S_STORE, S_DISCARD} pstate_t;

   pstate_t           state, state_d;
   logic [7:0]        mem [N_SLOTS][SLOT_LEN];
   logic [7:0]        lbuf [SLOT_LEN];
   logic [LEN_W-1:0]  slot_len [N_SLOTS];
   logic [LEN_W-1:0]  cnt;
   logic [3:0]        addr_hi;
   logic [7:0]        addr_full;
   logic [SLOT_W-1:0] wslot;
   logic              err_set, hi_ld, lo_ld, cnt_clr, app;
   logic [1:0]        code_d;

   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] b);
      if (b <= 8'h39) return b[3:0];
      return b[3:0] + 4'd9;
   endfunction

`ifdef CMD_MEM_DEFAULTS_EN
   localparam pstate_t RST_STATE = S_INIT;
   logic [2:0] init_cnt;

   if (N_SLOTS < 7 || SLOT_LEN < 8) begin : g_cfg_check
      $error("CMD_MEM_DEFAULTS_EN needs N_SLOTS >= 7 and SLOT_LEN >= 8");
   end

   function automatic logic [LEN_W-1:0] def_len(input logic [2:0] s);
      case (s)
         3'd0:    return LEN_W'(2);
         3'd1:    return LEN_W'(7);
         3'd2:    return LEN_W'(6);
         3'd3:    return LEN_W'(7);
         default: return LEN_W'(8);
      endcase
   endfunction

   function automatic logic [7:0] def_byte(input logic [2:0] s, input int i);
      logic [63:0] str;
      int          n;
      case (s)
         3'd0:    begin str = {48'd0, "AT"};      n = 2; end
         3'd1:    begin str = {8'd0,  "AT+NAME"}; n = 7; end
         3'd2:    begin str = {16'd0, "AT+PIN"};  n = 6; end
         3'd3:    begin str = {8'd0,  "AT+BAUD"}; n = 7; end
         3'd4:    begin str = "AT+ROLE0";         n = 8; end
         3'd5:    begin str = "AT+RESET";         n = 8; end
         default: begin str = "AT+ADVEN";         n = 8; end
      endcase
      if (i < n) return str[8*(n-1-i) +: 8];
      return 8'h00;
   endfunction

   assign init_busy = (state == S_INIT) && !rst;
`else
   localparam pstate_t RST_STATE = S_IDLE;
   assign init_busy = 1'b0;
`endif

   assign addr_full = {addr_hi, hex_val(rx_data)};
   assign wr_done   = (state == S_STORE);
   assign wr_slot   = wslot;

   always_comb begin
      state_d = state;
      err_set = 1'b0;
      code_d  = 2'd0;
      hi_ld   = 1'b0;
      lo_ld   = 1'b0;
      cnt_clr = 1'b0;
      app     = 1'b0;
      case (state)
`ifdef CMD_MEM_DEFAULTS_EN
         S_INIT:  if (init_cnt == 3'd6) state_d = S_IDLE;
`endif
         S_STORE: state_d = S_IDLE;
         default: if (rx_valid) begin
            if (rx_data == ESC) state_d = S_IDLE;
            else begin
               case (state)
                  S_IDLE:
                     if (is_hex(rx_data)) begin hi_ld = 1'b1; state_d = S_ADDR2; end
                     else begin state_d = S_DISCARD; err_set = 1'b1; code_d = ERR_ADDR; end
                  S_ADDR2:
                     if (is_hex(rx_data) && int'(addr_full) < N_SLOTS) begin lo_ld = 1'b1; state_d = S_SPACE; end
                     else begin state_d = S_DISCARD; err_set = 1'b1; code_d = ERR_ADDR; end
                  S_SPACE:
                     if (rx_data == SP) begin cnt_clr = 1'b1; state_d = S_DATA; end
                     else begin state_d = S_DISCARD; err_set = 1'b1; code_d = ERR_SPACE; end
                  S_DATA:
                     if (rx_data == CR) state_d = S_LF;
                     else if (cnt == LEN_W'(SLOT_LEN)) begin state_d = S_DISCARD; err_set = 1'b1; code_d = ERR_WDH; end
                     else app = 1'b1;
                  S_LF:
                     if (rx_data == LF) state_d = S_STORE;
                     else begin state_d = S_DISCARD; err_set = 1'b1; code_d = ERR_WDH; end
                  S_DISCARD:
                     if (rx_data == LF) state_d = S_IDLE;
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RST_STATE;
         err_valid <= 1'b0;
         err_code  <= 2'd0;
         cnt       <= '0;
         addr_hi   <= '0;
         wslot     <= '0;
         for (int i = 0; i < N_SLOTS; i++) slot_len[i] <= '0;
`ifdef CMD_MEM_DEFAULTS_EN
         init_cnt  <= '0;
`endif
      end else begin
         state     <= state_d;
         err_valid <= err_set;
         if (err_set) err_code <= code_d;
         if (hi_ld) addr_hi <= hex_val(rx_data);
         if (lo_ld) wslot <= SLOT_W'(addr_full);
         if (cnt_clr) cnt <= '0;
         else if (app) cnt <= cnt + LEN_W'(1);
         if (state == S_STORE) slot_len[wslot] <= cnt;
`ifdef CMD_MEM_DEFAULTS_EN
         if (state == S_INIT) begin
            slot_len[SLOT_W'(init_cnt)] <= def_len(init_cnt);
            init_cnt <= init_cnt + 3'd1;
         end
`endif
      end
   end

   // Payload bytes: the whole line buffer lands in the slot in the single STORE cycle
   always_ff @(posedge clk) begin
      if (app) lbuf[cnt[BI_W-1:0]] <= rx_data;
      if (state == S_STORE)
         for (int i = 0; i < SLOT_LEN; i++) mem[wslot][i] <= lbuf[i];
`ifdef CMD_MEM_DEFAULTS_EN
      if (state == S_INIT)
         for (int i = 0; i < SLOT_LEN; i++) mem[SLOT_W'(init_cnt)][i] <= def_byte(init_cnt, i);
`endif
   end

   logic [SLOT_W-1:0] rd_slot_q;
   logic [LEN_W-1:0]  rd_len_q;
   logic [IDX_W-1:0]  rd_idx, len_x, rd_last;

   assign len_x    = IDX_W'(rd_len_q);
   assign rd_last  = len_x + IDX_W'(1);
   assign tx_valid = rd_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_busy   <= 1'b0;
         rd_err    <= 1'b0;
         rd_slot_q <= '0;
         rd_len_q  <= '0;
         rd_idx    <= '0;
      end else begin
         rd_err <= 1'b0;
         if (!rd_busy) begin
            if (rd_req) begin
               if (int'(rd_slot) >= N_SLOTS) rd_err <= 1'b1;
               else begin
                  rd_busy   <= 1'b1;
                  rd_slot_q <= rd_slot;
                  rd_len_q  <= slot_len[rd_slot];
                  rd_idx    <= '0;
               end
            end
         end else if (tx_ready) begin
            if (rd_idx == rd_last) rd_busy <= 1'b0;
            else rd_idx <= rd_idx + IDX_W'(1);
         end
      end
   end

   // Payload bytes are read live so a concurrent STORE to the same slot shows through
   always_comb begin
      tx_data = 8'h00;
      if (rd_busy) begin
         if (rd_idx < len_x) tx_data = mem[rd_slot_q][rd_idx[BI_W-1:0]];
         else if (rd_idx == len_x) tx_data = CR;
         else tx_data = LF;
      end
   end
endmodule

// File: tb/tb_ble_cmd_store.sv
// Directed bench for ble_cmd_store with a line-level model of slot contents and parser outcomes.
`timescale 1ns/1ps
module tb_ble_cmd_store;
   // 12 slots so an out-of-range slot number is representable on the SLOT_W-bit rd_slot port
   localparam int N  = 12;
   localparam int L  = 32;
   localparam int SW = $clog2(N);
`ifdef CMD_MEM_DEFAULTS_EN
   localparam int INIT_N = 7;
`else
   localparam int INIT_N = 0;
`endif

   logic          clk = 1'b0, rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0, rd_req = 1'b0, tx_ready = 1'b1;
   logic [SW-1:0] rd_slot = '0;
   logic          wr_done, err_valid, rd_busy, rd_err, tx_valid, init_busy;
   logic [SW-1:0] wr_slot;
   logic [1:0]    err_code;
   logic [7:0]    tx_data;

   always #5 clk = ~clk;

   ble_cmd_store #(.N_SLOTS(N), .SLOT_LEN(L)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .wr_done(wr_done), .wr_slot(wr_slot), .err_valid(err_valid), .err_code(err_code),
      .rd_req(rd_req), .rd_slot(rd_slot), .rd_busy(rd_busy), .rd_err(rd_err),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .init_busy(init_busy)
   );

   int         n_chk = 0, n_pass = 0;
   string      exp_mem [N];
   logic       exp_wr = 1'b0, exp_err = 1'b0;
   logic [1:0] exp_code = 2'd0;
   int         exp_slot = 0;
   bit         chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wr_done", int'(wr_done), int'(exp_wr));
         if (exp_wr) chk("wr_slot", int'(wr_slot), exp_slot);
         chk("err_valid", int'(err_valid), int'(exp_err));
         chk("err_code", int'(err_code), int'(exp_code));
         chk("init_busy", int'(init_busy), 0);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < N; i++) exp_mem[i] = "";
`ifdef CMD_MEM_DEFAULTS_EN
      exp_mem[0] = "AT";       exp_mem[1] = "AT+NAME";  exp_mem[2] = "AT+PIN";
      exp_mem[3] = "AT+BAUD";  exp_mem[4] = "AT+ROLE0"; exp_mem[5] = "AT+RESET";
      exp_mem[6] = "AT+ADVEN";
`endif
      exp_code = 2'd0;
   endtask

   function automatic bit hexc(input byte b);
      return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
   endfunction

   function automatic int hv(input byte b);
      if (b <= "9") return int'(b) - 48;
      if (b <= "F") return int'(b) - 55;
      return int'(b) - 87;
   endfunction

   // Outcome of a whole line: index of the byte that triggers the event, code 0 = stored
   function automatic void analyze(input string s, output int trig, output int code,
                                   output int slot, output string pay);
      int p;
      trig = -1; code = 0; slot = 0; pay = "";
      if (!hexc(s[0])) begin trig = 0; code = 2; return; end
      if (!hexc(s[1])) begin trig = 1; code = 2; return; end
      slot = hv(s[0]) * 16 + hv(s[1]);
      if (slot >= N) begin trig = 1; code = 2; return; end
      if (s[2] != " ") begin trig = 2; code = 3; return; end
      p = 3;
      while (p < s.len() && s[p] != 8'h0D) p++;
      if (p - 3 > L) begin trig = 3 + L; code = 1; return; end
      if (p + 1 >= s.len() || s[p+1] != 8'h0A) begin trig = p + 1; code = 1; return; end
      trig = p + 1;
      pay  = s.substr(3, p - 1);
   endfunction

   task automatic send_raw(input string s, input int trig, input int code, input int slot);
      for (int i = 0; i < s.len(); i++) begin
         rx_data = s[i]; rx_valid = 1'b1;
         @(posedge clk); #1 rx_valid = 1'b0;
         if (i == trig) begin
            if (code == 0) begin exp_wr = 1'b1; exp_slot = slot; end
            else begin exp_err = 1'b1; exp_code = code[1:0]; end
         end
         @(posedge clk); #1 exp_wr = 1'b0; exp_err = 1'b0;
      end
   endtask

   task automatic send_line(input string s);
      int trig, code, slot;
      string pay;
      analyze(s, trig, code, slot, pay);
      send_raw(s, trig, code, slot);
      if (code == 0) exp_mem[slot] = pay;
   endtask

   task automatic read_slot(input int s, input bit rnd, input string exp_s);
      logic [7:0] got[$];
      logic [7:0] held;
      bit         stalled;
      int         cyc;
      string      full;
      full = {exp_s, "\015\n"};
      tx_ready = 1'b1; rd_slot = SW'(s); rd_req = 1'b1;
      @(posedge clk); #1 rd_req = 1'b0;
      @(negedge clk);
      chk("rd_start", int'({rd_busy, tx_valid}), 3);
      cyc = 0; stalled = 1'b0; held = 8'h00;
      while (rd_busy && cyc < 400) begin
         if (stalled) chk("tx_hold", int'(tx_data), int'(held));
         if (tx_ready) begin got.push_back(tx_data); stalled = 1'b0; end
         else begin held = tx_data; stalled = 1'b1; end
         @(posedge clk); #1 if (rnd) tx_ready = 1'($urandom_range(0, 1));
         @(negedge clk); cyc++;
      end
      chk("rd_end_busy", int'(rd_busy), 0);
      chk("rd_end_valid", int'(tx_valid), 0);
      if (!rnd) chk("rd_beats", cyc, full.len());
      chk("rd_count", got.size(), full.len());
      for (int i = 0; i < got.size() && i < full.len(); i++) chk("rd_byte", int'(got[i]), int'(full[i]));
      tx_ready = 1'b1;
   endtask

   task automatic wait_init();
      int c = 0;
      @(negedge clk);
      while (init_busy && c < 20) begin c++; @(negedge clk); end
      chk("init_cycles", c, INIT_N);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string ov, full32;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_done", int'(wr_done), 0);
      chk("rst_wr_slot", int'(wr_slot), 0);
      chk("rst_err_valid", int'(err_valid), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_rd_busy", int'(rd_busy), 0);
      chk("rst_rd_err", int'(rd_err), 0);
      chk("rst_tx_valid", int'(tx_valid), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_init_busy", int'(init_busy), 0);
      rst = 1'b0;
      wait_init();
      chk_en = 1'b1;

      send_line("0A AT+ROLE0\015\n");
      chk("model_pin_0A", int'(exp_mem[10] == "AT+ROLE0"), 1);
      read_slot(10, 1'b0, "AT+ROLE0");
      send_line("03 keep\015\n");
      read_slot(3, 1'b0, "keep");

      send_line("1G x\015\n");
      chk("code_addr_hex", int'(err_code), 2);
      read_slot(1, 1'b0, exp_mem[1]);

      ov = "02 ";
      for (int i = 0; i < L + 1; i++) ov = {ov, "a"};
      ov = {ov, "\015\n"};
      send_line(ov);
      chk("code_overflow", int'(err_code), 1);
      read_slot(2, 1'b0, exp_mem[2]);

      send_line("03X\015\n");
      chk("code_space", int'(err_code), 3);
      read_slot(3, 1'b0, "keep");

      send_line("03 a\015B\n");
      chk("code_bad_lf", int'(err_code), 1);
      read_slot(3, 1'b0, "keep");

      send_line("10 AT\015\n");
      chk("code_addr_range", int'(err_code), 2);
      send_line("0C AT\015\n");
      send_line("0B top\015\n");
      read_slot(11, 1'b0, "top");

      rd_slot = SW'(12); rd_req = 1'b1;
      @(posedge clk); #1 rd_req = 1'b0;
      @(negedge clk);
      chk("rd_err_pulse", int'(rd_err), 1);
      chk("rd_err_busy", int'(rd_busy), 0);
      @(negedge clk);
      chk("rd_err_clear", int'(rd_err), 0);
      chk("rd_err_busy2", int'(rd_busy), 0);

      read_slot(10, 1'b1, "AT+ROLE0");
      full32 = "0123456789ABCDEFGHIJKLMNOPQRSTUV";
      send_line({"04 ", full32, "\015\n"});
      read_slot(4, 1'b1, full32);
      send_line("05 \015\n");
      read_slot(5, 1'b0, "");

      send_raw("07 ab\033", -1, 0, 0);
      send_line("07 xyz\015\n");
      read_slot(7, 1'b0, "xyz");

      send_raw("06 abc", -1, 0, 0);
      tx_ready = 1'b0; rd_slot = SW'(10); rd_req = 1'b1;
      @(posedge clk); #1 rd_req = 1'b0;
      @(negedge clk);
      chk("stall_valid", int'(tx_valid), 1);
      chk_en = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_tx_valid", int'(tx_valid), 0);
      chk("arst_rd_busy", int'(rd_busy), 0);
      chk("arst_tx_data", int'(tx_data), 0);
      chk("arst_wr_done", int'(wr_done), 0);
      chk("arst_err_code", int'(err_code), 0);
      chk("arst_init_busy", int'(init_busy), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tx_ready = 1'b1;
      model_reset();
      wait_init();
      chk_en = 1'b1;
`ifdef CMD_MEM_DEFAULTS_EN
      read_slot(6, 1'b0, "AT+ADVEN");
`else
      read_slot(6, 1'b0, "");
`endif
      read_slot(10, 1'b0, exp_mem[10]);
      send_line("09 ok\015\n");
      read_slot(9, 1'b0, "ok");

      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
